// File: rtl/dmem_responder_if.sv
// Request/response channel between the CPU datapath and the data memory responder.
// The CPU drives the master side; the memory drives the slave side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle 16-bit data memory with valid/ready request and response channels.
// Byte addressed; word index is addr>>1; misaligned or out-of-range accesses report rsp_err.
module dmem_responder #(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 2
) (
    input  logic              clock,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic              busy
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic               lat_write;
    logic [15:0]        lat_addr;
    logic [15:0]        lat_wdata;
    logic [15:0]        mem [DEPTH];

    logic               accept;
    logic               commit;
    logic               lat_err;
    logic [IDX_W-1:0]   lat_idx;

    function automatic logic addr_err(input logic [15:0] a);
        return a[0] || (32'(a[15:1]) >= DEPTH);
    endfunction

    assign accept  = bus.req_valid & bus.req_ready;
    assign commit  = (state == S_WAIT) && (cnt == 4'd0);
    assign lat_err = addr_err(lat_addr);
    assign lat_idx = lat_addr[IDX_W:1];

    // Request capture: only loaded on an accepted handshake, so no reset needed.
    always_ff @(posedge clock) begin
        if (accept) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
        end
    end

    // Store commit; a reset before this edge returns the FSM to idle and drops the write.
    always_ff @(posedge clock) begin
        if (commit && lat_write && !lat_err) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 16'h0000;
            bus.rsp_err   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state         <= S_WAIT;
                        cnt           <= WAIT_CNT;
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // Counter reaches zero after WAIT cycles; the next edge enters RESP.
                    if (cnt == 4'd0) begin
                        state         <= S_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= lat_err;
                        bus.rsp_rdata <= (!lat_write && !lat_err) ? mem[lat_idx] : 16'h0000;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= S_IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= 16'h0000;
                        bus.req_ready <= 1'b1;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    bus.req_ready <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT=2 instance for the main sequence and
// a WAIT=0 instance for the single-cycle latency case.
module tb_dmem_responder;

    logic clock;
    logic reset;
    logic busy;
    logic busy0;
    int   total;
    int   passed;

    dmem_responder_if bus();
    dmem_responder_if bus0();

    dmem_responder #(.DEPTH(1024), .WAIT(2)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    dmem_responder #(.DEPTH(1024), .WAIT(0)) u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0),
        .busy  (busy0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full transaction on the WAIT=2 instance with rsp_ready held high.
    task automatic do_txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rdata, output logic err, output int lat);
        int k;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = 1'b1;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) chk("req_ready_timeout", 16'(bus.req_ready), 16'h0001);
        tick();
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        tick();
    endtask

    logic [15:0] rd;
    logic        er;
    int          lt;

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 16'h0000;
        bus.req_wdata  = 16'h0000;
        bus.rsp_ready  = 1'b0;
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'b0;
        bus0.req_addr  = 16'h0000;
        bus0.req_wdata = 16'h0000;
        bus0.rsp_ready = 1'b0;

        // 1. reset asserted mid-cycle, outputs clear without a clock edge
        #12 reset = 1'b1;
        #1;
        chk("rst_req_ready", 16'(bus.req_ready), 16'h0000);
        chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'h0000);
        chk("rst_rsp_err",   16'(bus.rsp_err),   16'h0000);
        chk("rst_busy",      16'(busy),          16'h0000);
        @(posedge clock);
        #3 reset = 1'b0;
        tick();
        chk("rel_req_ready", 16'(bus.req_ready), 16'h0001);

        // preload mem[0] = 5
        do_txn(1'b1, 16'h0000, 16'h0005, rd, er, lt);
        chk("pre_lat", 16'(lt), 16'h0003);
        chk("pre_err", 16'(er), 16'h0000);

        // 2. WAIT=2 load, cycle by cycle
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk("ld_busy_n",     16'(busy),          16'h0001);
        chk("ld_valid_n",    16'(bus.rsp_valid), 16'h0000);
        tick();
        tick();
        chk("ld_valid_n2",   16'(bus.rsp_valid), 16'h0000);
        tick();
        chk("ld_valid_n3",   16'(bus.rsp_valid), 16'h0001);
        chk("ld_rdata_n3",   bus.rsp_rdata,      16'h0005);
        chk("ld_err_n3",     16'(bus.rsp_err),   16'h0000);
        tick();
        chk("ld_valid_n4",   16'(bus.rsp_valid), 16'h0000);
        chk("ld_ready_n4",   16'(bus.req_ready), 16'h0001);
        chk("ld_busy_n4",    16'(busy),          16'h0000);

        // 3. store then load
        do_txn(1'b1, 16'h0002, 16'h0007, rd, er, lt);
        chk("st_rdata", rd,       16'h0000);
        chk("st_err",   16'(er),  16'h0000);
        do_txn(1'b0, 16'h0002, 16'h0000, rd, er, lt);
        chk("raw_rdata", rd,      16'h0007);

        // 4. back-pressure with a new store request held during the stall
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        tick();
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0004;
        bus.req_wdata = 16'h0044;
        tick();
        chk("bp_ready_wait", 16'(bus.req_ready), 16'h0000);
        tick();
        tick();
        chk("bp_valid_rise", 16'(bus.rsp_valid), 16'h0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_hold", 16'(bus.rsp_valid), 16'h0001);
            chk("bp_rdata_hold", bus.rsp_rdata,      16'h0005);
            chk("bp_ready_hold", 16'(bus.req_ready), 16'h0000);
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_hs_valid", 16'(bus.rsp_valid), 16'h0000);
        chk("bp_hs_busy",  16'(busy),          16'h0000);
        chk("bp_hs_ready", 16'(bus.req_ready), 16'h0001);
        tick();
        bus.req_valid = 1'b0;
        chk("bp_new_busy", 16'(busy), 16'h0001);
        lt = 0;
        while (!bus.rsp_valid && lt < 20) begin
            tick();
            lt++;
        end
        chk("bp_new_lat", 16'(lt), 16'h0003);
        chk("bp_new_err", 16'(bus.rsp_err), 16'h0000);
        tick();
        do_txn(1'b0, 16'h0004, 16'h0000, rd, er, lt);
        chk("bp_new_data", rd, 16'h0044);

        // 5. error responses and the last valid word
        do_txn(1'b0, 16'h0003, 16'h0000, rd, er, lt);
        chk("mis_err",   16'(er), 16'h0001);
        chk("mis_rdata", rd,      16'h0000);
        do_txn(1'b0, 16'h0800, 16'h0000, rd, er, lt);
        chk("oor_err",   16'(er), 16'h0001);
        chk("oor_rdata", rd,      16'h0000);
        do_txn(1'b1, 16'h0801, 16'hFFFF, rd, er, lt);
        chk("oor_st_err", 16'(er), 16'h0001);
        do_txn(1'b0, 16'h0000, 16'h0000, rd, er, lt);
        chk("oor_keep0", rd, 16'h0005);
        do_txn(1'b0, 16'h0002, 16'h0000, rd, er, lt);
        chk("oor_keep1", rd, 16'h0007);
        do_txn(1'b1, 16'h07FE, 16'h1234, rd, er, lt);
        chk("top_st_err", 16'(er), 16'h0000);
        do_txn(1'b0, 16'h07FE, 16'h0000, rd, er, lt);
        chk("top_ld",     rd,      16'h1234);
        chk("top_ld_err", 16'(er), 16'h0000);

        // 6a. WAIT=0 instance: response one cycle after accept
        bus0.req_valid = 1'b1;
        bus0.req_write = 1'b1;
        bus0.req_addr  = 16'h0000;
        bus0.req_wdata = 16'hA5A5;
        bus0.rsp_ready = 1'b1;
        tick();
        bus0.req_valid = 1'b0;
        chk("w0_st_valid_n",  16'(bus0.rsp_valid), 16'h0000);
        tick();
        chk("w0_st_valid_n1", 16'(bus0.rsp_valid), 16'h0001);
        chk("w0_st_err",      16'(bus0.rsp_err),   16'h0000);
        tick();
        bus0.req_valid = 1'b1;
        bus0.req_write = 1'b0;
        tick();
        bus0.req_valid = 1'b0;
        tick();
        chk("w0_ld_valid_n1", 16'(bus0.rsp_valid), 16'h0001);
        chk("w0_ld_rdata",    bus0.rsp_rdata,      16'hA5A5);
        tick();

        // 6b. reset during a store's wait states discards the store
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0002;
        bus.req_wdata = 16'hBEEF;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("rs_busy_pre", 16'(busy), 16'h0001);
        #2 reset = 1'b1;
        #1;
        chk("rs_busy",  16'(busy),          16'h0000);
        chk("rs_valid", 16'(bus.rsp_valid), 16'h0000);
        @(posedge clock);
        #3 reset = 1'b0;
        tick();
        chk("rs_ready", 16'(bus.req_ready), 16'h0001);
        do_txn(1'b0, 16'h0002, 16'h0000, rd, er, lt);
        chk("rs_keep", rd, 16'h0007);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
